// File: rtl/pipe_cla_alu_if.sv
// Operand/result handshake bundle for pipe_cla_alu.
// Valid/ready: a beat moves across either side on a rising edge where valid and ready are both 1.
interface pipe_cla_alu_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, op, a, b, cin, out_ready,
        input  in_ready, out_valid, result, cout, ovf, zero
    );

    modport slave (
        input  in_valid, op, a, b, cin, out_ready,
        output in_ready, out_valid, result, cout, ovf, zero
    );
endinterface

// File: rtl/pipe_cla_alu.sv
// Two-stage carry-lookahead add/sub/accumulate unit: low half in stage 1, high half plus flags in stage 2.
// Valid/ready: in/out beats transfer on a rising edge with valid & ready; out data is frozen while out_valid & ~out_ready.
module pipe_cla_alu #(
    parameter int WIDTH  = 16,
    parameter int ACC_EN = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    pipe_cla_alu_if.slave bus
);
    localparam int HALF = WIDTH / 2;
    localparam int NGRP = HALF / 4;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_CLR = 2'b11
    } op_e;

    // Returns {carry_out, sum}; group carries are flat sum-of-products over group P/G.
    function automatic logic [HALF:0] cla_half(input logic [HALF-1:0] x,
                                               input logic [HALF-1:0] y,
                                               input logic            ci);
        logic [HALF-1:0] g, p, c;
        logic [NGRP-1:0] gg, gp;
        logic [NGRP:0]   gc;
        logic            term;
        g = x & y;
        p = x ^ y;
        for (int k = 0; k < NGRP; k++) begin
            gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end
        gc    = '0;
        gc[0] = ci;
        for (int k = 0; k < NGRP; k++) begin
            term = ci;
            for (int j = 0; j <= k; j++) term = term & gp[j];
            gc[k+1] = term;
            for (int j = 0; j <= k; j++) begin
                term = gg[j];
                for (int m = j + 1; m <= k; m++) term = term & gp[m];
                gc[k+1] = gc[k+1] | term;
            end
        end
        for (int k = 0; k < NGRP; k++) begin
            c[4*k]   = gc[k];
            c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
        end
        return {gc[NGRP], p ^ c};
    endfunction

    logic             s1_valid, s2_valid;
    op_e              s1_op, s2_op;
    logic [HALF-1:0]  s1_lo, s1_xhi, s1_yhi;
    logic             s1_cmid;
    logic [WIDTH-1:0] s2_result, acc;
    logic             s2_cout, s2_ovf, s2_zero;

    op_e              in_op;
    logic [WIDTH-1:0] x, y;
    logic             c0;
    logic [HALF:0]    lo, hi;
    logic [WIDTH-1:0] res2;
    logic             ovf2;
    logic             s2_free, hazard, in_fire, out_fire;

    // With the accumulator disabled, ACC/CLR encodings fall back to a plain ADD.
    always_comb begin
        in_op = op_e'(bus.op);
        if (ACC_EN == 0 && bus.op[1]) in_op = OP_ADD;
    end

    always_comb begin
        x  = bus.a;
        y  = bus.b;
        c0 = bus.cin;
        case (in_op)
            OP_SUB: begin y = ~bus.b; c0 = 1'b1; end
            OP_ACC: begin x = acc; y = bus.a; c0 = 1'b0; end
            OP_CLR: begin x = '0; y = '0; c0 = 1'b0; end
            default: ;
        endcase
    end

    assign lo   = cla_half(x[HALF-1:0], y[HALF-1:0], c0);
    assign hi   = cla_half(s1_xhi, s1_yhi, s1_cmid);
    assign res2 = {hi[HALF-1:0], s1_lo};
    assign ovf2 = (s1_xhi[HALF-1] == s1_yhi[HALF-1]) && (res2[WIDTH-1] != s1_xhi[HALF-1]);

    // ACC/CLR in flight would change acc under a younger ACC, so intake stalls until they retire.
    assign s2_free      = ~s2_valid | bus.out_ready;
    assign hazard       = (s1_valid & s1_op[1]) | (s2_valid & s2_op[1]);
    assign bus.in_ready = (~s1_valid | s2_free) & ~hazard;
    assign in_fire      = bus.in_valid & bus.in_ready;
    assign out_fire     = s2_valid & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_ADD;
            s1_lo    <= '0;
            s1_cmid  <= 1'b0;
            s1_xhi   <= '0;
            s1_yhi   <= '0;
        end else if (~s1_valid | s2_free) begin
            s1_valid <= in_fire;
            if (in_fire) begin
                s1_op   <= in_op;
                s1_lo   <= lo[HALF-1:0];
                s1_cmid <= lo[HALF];
                s1_xhi  <= x[WIDTH-1:HALF];
                s1_yhi  <= y[WIDTH-1:HALF];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_op     <= OP_ADD;
            s2_result <= '0;
            s2_cout   <= 1'b0;
            s2_ovf    <= 1'b0;
            s2_zero   <= 1'b0;
        end else if (s2_free) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_op     <= s1_op;
                s2_result <= res2;
                s2_cout   <= hi[HALF];
                s2_ovf    <= ovf2;
                s2_zero   <= (res2 == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (out_fire) begin
            case (s2_op)
                OP_ACC:  acc <= s2_result;
                OP_CLR:  acc <= '0;
                default: ;
            endcase
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.result    = s2_result;
    assign bus.cout      = s2_cout;
    assign bus.ovf       = s2_ovf;
    assign bus.zero      = s2_zero;
endmodule
